// File: rtl/swim_pkg.sv
// Shared types and constants for the SWIM entry controller.
package swim_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST_HOLD  = 3'd1,
    ENT_LOW   = 3'd2,
    ENT_PULSE = 3'd3,
    WAIT_SYNC = 3'd4,
    REPLY     = 3'd5
  } swim_state_t;

  // Host command bytes
  localparam logic [7:0] CMD_RST    = 8'h52;
  localparam logic [7:0] CMD_ENTRY  = 8'h45;
  localparam logic [7:0] CMD_STATUS = 8'h53;

  // Reply bytes
  localparam logic [7:0] RSP_RST     = 8'h72;
  localparam logic [7:0] RSP_OK      = 8'h65;
  localparam logic [7:0] RSP_TIMEOUT = 8'h21;
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;

  // Entry pulse half-period lengths in ticks: phases 0-7 slow, 8-15 fast
  localparam int unsigned PHASE_TICKS_SLOW = 4;
  localparam int unsigned PHASE_TICKS_FAST = 2;

endpackage

// File: rtl/swim_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV cycles.
// clear restarts the count so the next tick lands exactly TICK_DIV cycles later.
module swim_tick_gen #(
  parameter int unsigned TICK_DIV = 6000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV) + 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  // Prescaler: count 0..TICK_DIV-1, wrap on tick, restart on clear
  always_ff @(posedge clk) begin
    if (reset || clear || tick) cnt_q <= '0;
    else                        cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/swim_entry_ctrl.sv
// SWIM entry controller: takes one host command at a time, sequences target
// reset and the SWIM entry pulse train, watches for the target sync pulse and
// returns one status byte per command.
//
// Handshakes: a byte moves on a rising edge where valid && ready are both high.
// in_ready is high only in IDLE; out_valid is high only in REPLY and out_data
// holds steady until out_ready is seen.
module swim_entry_ctrl
  import swim_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 6000,
  parameter int unsigned RST_TICKS    = 8,
  parameter int unsigned SYNC_MIN     = 512,
  parameter int unsigned SYNC_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        swim_in,
  output logic        swim_oe,
  output logic        nrst_n,
  output logic        busy,
  output swim_state_t dbg_state
);

  localparam int unsigned MAX_A = (RST_TICKS > SYNC_TIMEOUT) ? RST_TICKS : SYNC_TIMEOUT;
  localparam int unsigned MAX_TICKS = (MAX_A > PHASE_TICKS_SLOW) ? MAX_A : PHASE_TICKS_SLOW;
  localparam int TW = $clog2(MAX_TICKS) + 1;
  localparam int LW = $clog2(SYNC_MIN) + 1;

  swim_state_t   state_q, state_nx;
  logic [3:0]    phase_q, phase_nx;
  logic [TW-1:0] tick_cnt_q, tick_cnt_nx;
  logic [LW-1:0] low_cnt_q, low_cnt_nx;
  logic          entered_q, entered_nx;
  logic          last_timeout_q, last_timeout_nx;
  logic [7:0]    rsp_q, rsp_nx;
  logic          swim_oe_q, swim_oe_nx;
  logic          nrst_n_q, nrst_n_nx;
  logic          sync1_q, sync2_q;
  logic          tick, transition, sync_hit;
  logic [TW-1:0] phase_len_m1;

  swim_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (transition),
    .tick  (tick)
  );

  // Two-flop synchronizer; the line idles high (pulled up)
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= swim_in;
      sync2_q <= sync1_q;
    end
  end

  assign phase_len_m1 = phase_q[3] ? TW'(PHASE_TICKS_FAST - 1) : TW'(PHASE_TICKS_SLOW - 1);
  assign sync_hit     = (state_q == WAIT_SYNC) && !sync2_q && (low_cnt_q == LW'(SYNC_MIN - 1));

  // Next-state, counters, status flags, reply byte and registered pin values
  always_comb begin
    state_nx        = state_q;
    phase_nx        = phase_q;
    tick_cnt_nx     = tick ? tick_cnt_q + 1'b1 : tick_cnt_q;
    entered_nx      = entered_q;
    last_timeout_nx = last_timeout_q;
    rsp_nx          = rsp_q;
    low_cnt_nx      = ((state_q == WAIT_SYNC) && !sync2_q) ? low_cnt_q + 1'b1 : '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (in_data)
            CMD_RST:    state_nx = RST_HOLD;
            CMD_ENTRY:  state_nx = ENT_LOW;
            CMD_STATUS: begin
              state_nx = REPLY;
              rsp_nx   = {6'b0, entered_q, last_timeout_q};
            end
            default: begin
              state_nx = REPLY;
              rsp_nx   = RSP_UNKNOWN;
            end
          endcase
        end
      end
      RST_HOLD: begin
        if (tick && tick_cnt_q == TW'(RST_TICKS - 1)) begin
          state_nx   = REPLY;
          entered_nx = 1'b0;
          rsp_nx     = RSP_RST;
        end
      end
      ENT_LOW: begin
        if (tick) begin
          state_nx = ENT_PULSE;
          phase_nx = 4'd0;
        end
      end
      ENT_PULSE: begin
        if (tick && tick_cnt_q == phase_len_m1) begin
          tick_cnt_nx = '0;
          if (phase_q == 4'd15) state_nx = WAIT_SYNC;
          else                  phase_nx = phase_q + 4'd1;
        end
      end
      WAIT_SYNC: begin
        // Sync takes priority over a timeout landing in the same cycle
        if (sync_hit) begin
          state_nx        = REPLY;
          entered_nx      = 1'b1;
          last_timeout_nx = 1'b0;
          rsp_nx          = RSP_OK;
        end else if (tick && tick_cnt_q == TW'(SYNC_TIMEOUT - 1)) begin
          state_nx        = REPLY;
          entered_nx      = 1'b0;
          last_timeout_nx = 1'b1;
          rsp_nx          = RSP_TIMEOUT;
        end
      end
      REPLY: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    transition = (state_nx != state_q);
    if (transition) tick_cnt_nx = '0;

    // Pin values follow the state being entered so they change with it
    swim_oe_nx = (state_nx == ENT_LOW) || ((state_nx == ENT_PULSE) && phase_nx[0]);
    nrst_n_nx  = !((state_nx == RST_HOLD) || (state_nx == ENT_LOW) ||
                   (state_nx == ENT_PULSE) || (state_nx == WAIT_SYNC));
  end

  // State, counters and output registers; reset aborts any sequence at once
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      phase_q        <= 4'd0;
      tick_cnt_q     <= '0;
      low_cnt_q      <= '0;
      entered_q      <= 1'b0;
      last_timeout_q <= 1'b0;
      rsp_q          <= 8'h00;
      swim_oe_q      <= 1'b0;
      nrst_n_q       <= 1'b1;
    end else begin
      state_q        <= state_nx;
      phase_q        <= phase_nx;
      tick_cnt_q     <= tick_cnt_nx;
      low_cnt_q      <= low_cnt_nx;
      entered_q      <= entered_nx;
      last_timeout_q <= last_timeout_nx;
      rsp_q          <= rsp_nx;
      swim_oe_q      <= swim_oe_nx;
      nrst_n_q       <= nrst_n_nx;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == REPLY);
  assign out_data  = rsp_q;
  assign busy      = (state_q != IDLE);
  assign swim_oe   = swim_oe_q;
  assign nrst_n    = nrst_n_q;
  assign dbg_state = state_q;

endmodule
